// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types: word, RAM handshake state, arbiter state
//
// Purpose: common types for the caches, the RAM model and the RAM arbiter.
//   word_t      - 32-bit data/address word
//   ramstate_t  - RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t - ram_arbiter FSM state, exported so bench monitors can decode it
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rtl/ram_arbiter_rr_picker.sv - combinational round-robin winner search
//
// Purpose: picks the first active requester searching ptr+1, ptr+2, ... modulo NREQ.
// Ports:
//   active  in  NREQ  requester active vector
//   ptr     in  IW    index of the last requester served
//   winner  out IW    chosen requester index (0 when nothing is active)
//   valid   out 1     at least one requester is active
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] active,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest active index after
  // ptr is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = |active;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (active[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM port among cache requesters
//
// Purpose: grants one requester at a time to the RAM port, holds the grant until
// the access completes (ramstate == ACCESS) or the requester withdraws, inserts a
// one-cycle DONE bubble, then rotates priority past the served requester.
// Optional feature macro: ARB_TIMEOUT_EN (forced abort after TIMEOUT XFER cycles).
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   req_ren/req_wen      per-requester read/write request
//   req_addr/req_store   per-requester address / write data
//   req_wait/req_load    per-requester wait (low on completion) / read data
//   ramREN/ramWEN        RAM read/write enable
//   ramaddr/ramstore     RAM address / write data
//   ramload/ramstate     RAM read data / handshake state
//   arb_busy             state is not IDLE
//   arb_timeout          one-cycle pulse on a forced abort
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  word_t [NREQ-1:0]     req_addr,
  input  word_t [NREQ-1:0]     req_store,
  output logic [NREQ-1:0]      req_wait,
  output word_t [NREQ-1:0]     req_load,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic                 arb_busy,
  output logic                 arb_timeout
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state, next_state;
  logic [IW-1:0]   gnt, ptr, pick;
  logic            pick_valid;
  logic [NREQ-1:0] active;
  logic            gnt_active;
  logic            access;
  logic            force_abort;

  assign active     = req_ren | req_wen;
  assign gnt_active = active[gnt];
  assign access     = (ramstate == ACCESS);

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .active (active),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign force_abort = (state == XFER) && !access && (tcnt == TW'(TIMEOUT));
  assign arb_timeout = force_abort;

  // Counts XFER cycles spent waiting; anything else (IDLE, DONE, completion) restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt <= '0;
    end else if (state == XFER && !access) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign force_abort = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= IW'(NREQ - 1);
    end else begin
      state <= next_state;
      if (state == IDLE && pick_valid) begin
        gnt <= pick;
      end
      if (state == DONE) begin
        ptr <= gnt;
      end
    end
  end

  // An abort (requester withdrew or timeout) ends the transfer exactly like a
  // completion; the requester simply never saw req_wait drop.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_valid) next_state = XFER;
      XFER:    if (access || !gnt_active || force_abort) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM side and requester side are only connected while in XFER.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = '1;
    req_load = '0;
    if (state == XFER) begin
      ramaddr       = req_addr[gnt];
      ramstore      = req_store[gnt];
      ramWEN        = req_wen[gnt];
      ramREN        = req_ren[gnt] & ~req_wen[gnt];
      req_wait[gnt] = !access;
      req_load[gnt] = ramload;
    end
  end

  assign arb_busy = (state != IDLE);

endmodule
